sdram_port_arbiter: RTL and testbench

Two-port arbiter placed in front of `SdramCtrlTester`. It shares the controller's single cmd/rsp stream pair between two requesters. Command selection is round-robin, and a stalled command keeps its grant until it is accepted. Read responses return in order, so the arbiter routes each response back to its issuing port using a FIFO of port IDs recorded when each read is accepted.

---
 rtl/sdram_arb_pkg.sv | 30 +++
 rtl/sdram_port_arbiter_if.sv | 23 ++
 rtl/sdram_arb_route_fifo.sv | 61 ++++++
 rtl/sdram_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM command/response arbiter.
// Defaults for address/data/mask widths live here so the interface and the RTL agree.
package sdram_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int MASK_W = DATA_W / 8;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              write;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } sdram_cmd_t;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic port_id_t other_port(input port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// One cmd/rsp stream pair. "master" issues commands and takes responses
// (the arbiter facing the controller); "slave" is the arbiter facing a requester.
interface sdram_port_arbiter_if;
  import sdram_arb_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  sdram_cmd_t        cmd_payload;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_payload_data;

  modport master (
    output cmd_valid, cmd_payload, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_data
  );

  modport slave (
    input  cmd_valid, cmd_payload, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_data
  );

endinterface

// File: rtl/sdram_arb_route_fifo.sv
// Port-ID FIFO recording which requester issued each outstanding read.
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module sdram_arb_route_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  port_id_t               push_id,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output port_id_t               head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  port_id_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter sharing one SDRAM controller cmd/rsp stream pair.
// Build option SDRAM_ARB_FIXED_PRIO_EN: port 0 always wins when unlocked.
//
// state      | meaning
// ARB_FREE   | grant picked fresh each cycle (round-robin or fixed priority)
// ARB_LOCKED | a command stalled on the controller; grant held until it fires
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int PEND_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  sdram_port_arbiter_if.slave         p0,
  sdram_port_arbiter_if.slave         p1,
  sdram_port_arbiter_if.master        io,
  output logic [$clog2(PEND_DEPTH):0] pending_count,
  output logic                        err_orphan_rsp
);

  arb_state_e state_q, state_d;
  port_id_t   grant_q, grant_d;
  port_id_t   pick;
  port_id_t   g;
  logic [1:0] req;
  sdram_cmd_t cmd_sel;
  logic       sel_valid;
  logic       rd_block;
  logic       cmd_valid_int;
  logic       cmd_fire;

  logic       fifo_full;
  logic       fifo_empty;
  port_id_t   fifo_head;
  logic       fifo_push;
  logic       fifo_pop;
  logic       rsp_live;
  logic       rsp_ready_int;

  assign req = {p1.cmd_valid, p0.cmd_valid};

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = PORT0;
    if (!req[PORT0] && req[PORT1]) begin
      pick = PORT1;
    end
  end
`else
  port_id_t last_q;
  port_id_t rr_other;

  assign rr_other = other_port(last_q);

  always_comb begin
    pick = rr_other;
    if (!req[rr_other] && req[last_q]) begin
      pick = last_q;
    end
  end

  // Reset to port 1 so port 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT1;
    end else if (cmd_fire) begin
      last_q <= g;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_FREE;
      grant_q <= PORT0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    g             = (state_q == ARB_LOCKED) ? grant_q : pick;
    cmd_sel       = (g == PORT1) ? p1.cmd_payload : p0.cmd_payload;
    sel_valid     = req[g];
    // A full FIFO blocks reads even if a response pops this cycle: no rsp->cmd path.
    rd_block      = ~cmd_sel.write & fifo_full;
    cmd_valid_int = sel_valid & ~rd_block & ~reset;
    cmd_fire      = cmd_valid_int & io.cmd_ready;

    case (state_q)
      ARB_FREE: begin
        if (cmd_valid_int && !io.cmd_ready) begin
          state_d = ARB_LOCKED;
          grant_d = g;
        end
      end
      ARB_LOCKED: begin
        if (cmd_fire) begin
          state_d = ARB_FREE;
        end
      end
      default: state_d = ARB_FREE;
    endcase
  end

  assign io.cmd_valid   = cmd_valid_int;
  assign io.cmd_payload = cmd_sel;
  assign p0.cmd_ready   = io.cmd_ready & ~rd_block & ~reset & (g == PORT0);
  assign p1.cmd_ready   = io.cmd_ready & ~rd_block & ~reset & (g == PORT1);

  assign fifo_push = cmd_fire & ~cmd_sel.write;

  sdram_arb_route_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_route_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .push_id (g),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head),
    .count   (pending_count)
  );

  // With nothing pending the controller is always drained so an orphan beat cannot hang it.
  assign rsp_ready_int = fifo_empty
                       | ((fifo_head == PORT1) ? p1.rsp_ready : p0.rsp_ready);
  assign rsp_live      = io.rsp_valid & ~fifo_empty & ~reset;
  assign fifo_pop      = rsp_live & rsp_ready_int;

  assign io.rsp_ready        = rsp_ready_int;
  assign p0.rsp_valid        = rsp_live & (fifo_head == PORT0);
  assign p1.rsp_valid        = rsp_live & (fifo_head == PORT1);
  assign p0.rsp_payload_data = io.rsp_payload_data;
  assign p1.rsp_payload_data = io.rsp_payload_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_orphan_rsp <= 1'b0;
    end else if (io.rsp_valid && fifo_empty) begin
      err_orphan_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter; expected grants and response routing
// are queued as stimulus is applied and popped as the DUT hands off beats.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pending_count;
  logic       err_orphan_rsp;

  sdram_port_arbiter_if p0_if ();
  sdram_port_arbiter_if p1_if ();
  sdram_port_arbiter_if io_if ();

  sdram_port_arbiter #(
    .PEND_DEPTH (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .p0             (p0_if),
    .p1             (p1_if),
    .io             (io_if),
    .pending_count  (pending_count),
    .err_orphan_rsp (err_orphan_rsp)
  );

  always #5 clk = ~clk;

  typedef struct {
    port_id_t          port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t cmd_q[$];
  exp_t rsp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input port_id_t p, input logic v, input logic wr,
                         input logic [ADDR_W-1:0] a);
    sdram_cmd_t c;
    c.address = a;
    c.write   = wr;
    c.data    = a[DATA_W-1:0] ^ 16'h5a5a;
    c.mask    = '1;
    if (p == PORT0) begin
      p0_if.cmd_valid   = v;
      p0_if.cmd_payload = c;
    end else begin
      p1_if.cmd_valid   = v;
      p1_if.cmd_payload = c;
    end
  endtask

  task automatic test_reset();
    reset                  = 1'b1;
    set_cmd(PORT0, 1'b1, 1'b0, 24'h000001);
    set_cmd(PORT1, 1'b1, 1'b0, 24'h000002);
    io_if.cmd_ready        = 1'b1;
    io_if.rsp_valid        = 1'b1;
    io_if.rsp_payload_data = 16'h0;
    p0_if.rsp_ready        = 1'b1;
    p1_if.rsp_ready        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({p1_if.cmd_ready, p0_if.cmd_ready, io_if.cmd_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_cmd got=%b exp=000",
               {p1_if.cmd_ready, p0_if.cmd_ready, io_if.cmd_valid});
    end
    checks++;
    if ({p1_if.rsp_valid, p0_if.rsp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_rsp_valid got=%b exp=00", {p1_if.rsp_valid, p0_if.rsp_valid});
    end
    checks++;
    if (pending_count !== 4'd0 || err_orphan_rsp !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=%0d/%b exp=0/0", pending_count, err_orphan_rsp);
    end
    step();
    reset           = 1'b0;
    p0_if.cmd_valid = 1'b0;
    p1_if.cmd_valid = 1'b0;
    io_if.rsp_valid = 1'b0;
  endtask

  task automatic test_alternate();
    logic [DATA_W-1:0] dat [4];
    exp_t              e;
    dat[0] = 16'hAAAA; dat[1] = 16'hBBBB; dat[2] = 16'hCCCC; dat[3] = 16'hDDDD;
    for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      cmd_q.push_back('{PORT0, 24'h000010, 16'h0});
      rsp_q.push_back('{PORT0, 24'h0, dat[i]});
`else
      e.port = (i % 2 == 0) ? PORT0 : PORT1;
      e.addr = (i % 2 == 0) ? 24'h000010 : 24'h000020;
      e.data = dat[i];
      cmd_q.push_back(e);
      rsp_q.push_back(e);
`endif
    end
    set_cmd(PORT0, 1'b1, 1'b0, 24'h000010);
    set_cmd(PORT1, 1'b1, 1'b0, 24'h000020);
    io_if.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (!(io_if.cmd_valid && io_if.cmd_ready) || cmd_q.size() == 0) begin
        failures++;
        $display("FAIL alt_fire cycle=%0d got_valid=%b exp_valid=1", i, io_if.cmd_valid);
      end else begin
        e = cmd_q.pop_front();
        if ({p1_if.cmd_ready, p0_if.cmd_ready} !== ((e.port == PORT1) ? 2'b10 : 2'b01) ||
            io_if.cmd_payload.address !== e.addr) begin
          failures++;
          $display("FAIL alt_grant cycle=%0d got=%b/%h exp_port=%0d/%h", i,
                   {p1_if.cmd_ready, p0_if.cmd_ready}, io_if.cmd_payload.address,
                   e.port, e.addr);
        end
      end
      step();
    end
    p0_if.cmd_valid = 1'b0;
    p1_if.cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending_count !== 4'd4) begin
      failures++;
      $display("FAIL alt_pending got=%0d exp=4", pending_count);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      io_if.rsp_valid        = 1'b1;
      io_if.rsp_payload_data = dat[i];
      @(negedge clk);
      checks++;
      if (rsp_q.size() == 0) begin
        failures++;
        $display("FAIL alt_rsp_queue got=empty exp=entry");
      end else begin
        e = rsp_q.pop_front();
        if ({p1_if.rsp_valid, p0_if.rsp_valid} !== ((e.port == PORT1) ? 2'b10 : 2'b01) ||
            ((e.port == PORT1) ? p1_if.rsp_payload_data : p0_if.rsp_payload_data) !== e.data) begin
          failures++;
          $display("FAIL alt_rsp_route beat=%0d got=%b exp_port=%0d exp_data=%h", i,
                   {p1_if.rsp_valid, p0_if.rsp_valid}, e.port, e.data);
        end
      end
      step();
    end
    io_if.rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending_count !== 4'd0) begin
      failures++;
      $display("FAIL alt_drain got=%0d exp=0", pending_count);
    end
    step();
  endtask

  task automatic test_lock();
    exp_t e;
    cmd_q.push_back('{PORT1, 24'h000030, 16'h0});
    cmd_q.push_back('{PORT0, 24'h000040, 16'h0});
    io_if.cmd_ready = 1'b0;
    set_cmd(PORT1, 1'b1, 1'b1, 24'h000030);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_cmd(PORT0, 1'b1, 1'b1, 24'h000040);
      @(negedge clk);
      checks++;
      if (io_if.cmd_valid !== 1'b1 || io_if.cmd_payload.address !== 24'h000030) begin
        failures++;
        $display("FAIL lock_hold cycle=%0d got=%b/%h exp=1/000030", i,
                 io_if.cmd_valid, io_if.cmd_payload.address);
      end
      step();
    end
    io_if.cmd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (!(io_if.cmd_valid && io_if.cmd_ready) || cmd_q.size() == 0) begin
        failures++;
        $display("FAIL lock_fire n=%0d got_valid=%b exp_valid=1", i, io_if.cmd_valid);
      end else begin
        e = cmd_q.pop_front();
        if ({p1_if.cmd_ready, p0_if.cmd_ready} !== ((e.port == PORT1) ? 2'b10 : 2'b01) ||
            io_if.cmd_payload.address !== e.addr) begin
          failures++;
          $display("FAIL lock_order n=%0d got=%b/%h exp_port=%0d/%h", i,
                   {p1_if.cmd_ready, p0_if.cmd_ready}, io_if.cmd_payload.address,
                   e.port, e.addr);
        end
      end
      step();
      if (i == 0) p1_if.cmd_valid = 1'b0;
    end
    p0_if.cmd_valid = 1'b0;
  endtask

  task automatic test_fifo_full();
    io_if.cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_cmd(PORT0, 1'b1, 1'b0, 24'h000100 + 24'(i));
      @(negedge clk);
      checks++;
      if ({io_if.cmd_valid, p1_if.cmd_ready, p0_if.cmd_ready} !== 3'b101) begin
        failures++;
        $display("FAIL full_fill n=%0d got=%b exp=101", i,
                 {io_if.cmd_valid, p1_if.cmd_ready, p0_if.cmd_ready});
      end
      step();
    end
    p0_if.cmd_valid = 1'b0;
    set_cmd(PORT1, 1'b1, 1'b1, 24'h000200);
    @(negedge clk);
    checks++;
    if ({io_if.cmd_valid, p1_if.cmd_ready, io_if.cmd_payload.write} !== 3'b111 ||
        pending_count !== 4'd8) begin
      failures++;
      $display("FAIL full_write_pass got=%b/%0d exp=111/8",
               {io_if.cmd_valid, p1_if.cmd_ready, io_if.cmd_payload.write}, pending_count);
    end
    step();
    p1_if.cmd_valid = 1'b0;
    set_cmd(PORT0, 1'b1, 1'b0, 24'h000108);
    @(negedge clk);
    checks++;
    if ({io_if.cmd_valid, p0_if.cmd_ready} !== 2'b00) begin
      failures++;
      $display("FAIL full_read_block got=%b exp=00", {io_if.cmd_valid, p0_if.cmd_ready});
    end
    step();
    io_if.rsp_valid        = 1'b1;
    io_if.rsp_payload_data = 16'h0F00;
    p0_if.rsp_ready        = 1'b1;
    @(negedge clk);
    checks++;
    if ({p0_if.rsp_valid, io_if.rsp_ready, io_if.cmd_valid} !== 3'b110) begin
      failures++;
      $display("FAIL full_pop_same_cycle got=%b exp=110",
               {p0_if.rsp_valid, io_if.rsp_ready, io_if.cmd_valid});
    end
    step();
    io_if.rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({io_if.cmd_valid, p0_if.cmd_ready} !== 2'b11 || pending_count !== 4'd7) begin
      failures++;
      $display("FAIL full_unblock got=%b/%0d exp=11/7",
               {io_if.cmd_valid, p0_if.cmd_ready}, pending_count);
    end
    step();
    p0_if.cmd_valid = 1'b0;
    io_if.rsp_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({p1_if.rsp_valid, p0_if.rsp_valid} !== 2'b01) begin
        failures++;
        $display("FAIL full_drain beat=%0d got=%b exp=01", i,
                 {p1_if.rsp_valid, p0_if.rsp_valid});
      end
      step();
    end
    io_if.rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending_count !== 4'd0) begin
      failures++;
      $display("FAIL full_empty got=%0d exp=0", pending_count);
    end
    step();
  endtask

  task automatic test_backpressure();
    exp_t e;
    rsp_q.push_back('{PORT0, 24'h000300, 16'h1234});
    rsp_q.push_back('{PORT1, 24'h000310, 16'h5678});
    io_if.cmd_ready = 1'b1;
    set_cmd(PORT0, 1'b1, 1'b0, 24'h000300);
    @(negedge clk);
    checks++;
    if (p0_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_issue0 got=%b exp=1", p0_if.cmd_ready);
    end
    step();
    p0_if.cmd_valid = 1'b0;
    set_cmd(PORT1, 1'b1, 1'b0, 24'h000310);
    @(negedge clk);
    checks++;
    if (p1_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_issue1 got=%b exp=1", p1_if.cmd_ready);
    end
    step();
    p1_if.cmd_valid        = 1'b0;
    io_if.rsp_valid        = 1'b1;
    io_if.rsp_payload_data = 16'h1234;
    p0_if.rsp_ready        = 1'b0;
    p1_if.rsp_ready        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({io_if.rsp_ready, p1_if.rsp_valid, p0_if.rsp_valid} !== 3'b001 ||
          pending_count !== 4'd2) begin
        failures++;
        $display("FAIL bp_stall cycle=%0d got=%b/%0d exp=001/2", i,
                 {io_if.rsp_ready, p1_if.rsp_valid, p0_if.rsp_valid}, pending_count);
      end
      step();
    end
    p0_if.rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_q.size() == 0) begin
        failures++;
        $display("FAIL bp_rsp_queue got=empty exp=entry");
      end else begin
        e = rsp_q.pop_front();
        if ({p1_if.rsp_valid, p0_if.rsp_valid} !== ((e.port == PORT1) ? 2'b10 : 2'b01) ||
            ((e.port == PORT1) ? p1_if.rsp_payload_data : p0_if.rsp_payload_data) !== e.data ||
            io_if.rsp_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_route beat=%0d got=%b/%b exp_port=%0d exp_data=%h", i,
                   {p1_if.rsp_valid, p0_if.rsp_valid}, io_if.rsp_ready, e.port, e.data);
        end
      end
      step();
      io_if.rsp_payload_data = 16'h5678;
    end
    io_if.rsp_valid = 1'b0;
  endtask

  task automatic test_orphan_and_reset();
    io_if.rsp_valid        = 1'b1;
    io_if.rsp_payload_data = 16'hDEAD;
    @(negedge clk);
    checks++;
    if ({io_if.rsp_ready, p1_if.rsp_valid, p0_if.rsp_valid, err_orphan_rsp} !== 4'b1000) begin
      failures++;
      $display("FAIL orphan_drop got=%b exp=1000",
               {io_if.rsp_ready, p1_if.rsp_valid, p0_if.rsp_valid, err_orphan_rsp});
    end
    step();
    io_if.rsp_valid = 1'b0;
    repeat (3) step();
    io_if.cmd_ready = 1'b1;
    set_cmd(PORT1, 1'b1, 1'b0, 24'h000500);
    @(negedge clk);
    checks++;
    if (err_orphan_rsp !== 1'b1 || pending_count !== 4'd0 || p1_if.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL orphan_sticky got=%b/%0d/%b exp=1/0/1",
               err_orphan_rsp, pending_count, p1_if.cmd_ready);
    end
    step();
    set_cmd(PORT0, 1'b1, 1'b1, 24'h000400);
    set_cmd(PORT1, 1'b1, 1'b1, 24'h000410);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pending_count !== 4'd1 || io_if.cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pre got=%0d/%b exp=1/0", pending_count, io_if.cmd_valid);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (err_orphan_rsp !== 1'b0 || pending_count !== 4'd0 ||
        {p1_if.cmd_ready, p0_if.cmd_ready} !== 2'b01 ||
        io_if.cmd_payload.address !== 24'h000400) begin
      failures++;
      $display("FAIL midreset_first got=%b/%0d/%b/%h exp=0/0/01/000400", err_orphan_rsp,
               pending_count, {p1_if.cmd_ready, p0_if.cmd_ready}, io_if.cmd_payload.address);
    end
    step();
    @(negedge clk);
    checks++;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    if ({p1_if.cmd_ready, p0_if.cmd_ready} !== 2'b01) begin
      failures++;
      $display("FAIL fixed_prio got=%b exp=01", {p1_if.cmd_ready, p0_if.cmd_ready});
    end
`else
    if ({p1_if.cmd_ready, p0_if.cmd_ready} !== 2'b10) begin
      failures++;
      $display("FAIL rr_second got=%b exp=10", {p1_if.cmd_ready, p0_if.cmd_ready});
    end
`endif
    step();
    p0_if.cmd_valid = 1'b0;
    p1_if.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_alternate();
    test_lock();
    test_fifo_full();
    test_backpressure();
    test_orphan_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
